data_sram_responder: RTL and testbench

- Memory-side responder for the CPU data-access interface.
- Accepts the chip-enable, write-enable, byte-lane select, address and write data produced by the MEM-stage load/store formatter.
- Performs word or byte-masked accesses on an internal synchronous word array.
- Returns the full 32-bit read word, plus a stall/data_ok handshake with a programmable number of wait states, so the pipeline can be exercised against slow memory.

---
 rtl/data_sram_responder.sv | 142 ++++++++++++++
 tb/tb_data_sram_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data interface: a synchronous word array
// with byte-lane writes and a stall/data_ok handshake with WAIT_CYCLES wait states.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [3:0]  memsel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        data_ok,
  output logic        err
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [3:0]             count_r;
  logic [ADDR_WIDTH-1:0]  idx_r;
  logic                   we_r;
  logic [3:0]             sel_r;
  logic [31:0]            wdata_r;
  logic [31:0]            rdata_r;
  logic                   data_ok_r;
  logic                   err_r;
  logic [31:0]            mem_r [DEPTH];

  logic                   accept_s;
  logic                   enter_done_s;
  logic                   wr_en_s;
  logic [ADDR_WIDTH-1:0]  acc_idx_s;
  logic                   acc_we_s;
  logic [3:0]             acc_sel_s;
  logic [31:0]            acc_wdata_s;
  logic                   unused_s;

  function automatic logic lane_ok(input logic [3:0] sel);
    case (sel)
      4'b1111, 4'b1100, 4'b0011,
      4'b1000, 4'b0100, 4'b0010, 4'b0001: lane_ok = 1'b1;
      default:                            lane_ok = 1'b0;
    endcase
  endfunction

  assign unused_s = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  // Select the access operands: live inputs when a zero-wait access completes
  // straight from IDLE, otherwise the values captured at accept time.
  always_comb begin
    accept_s     = 1'b0;
    enter_done_s = 1'b0;
    acc_idx_s    = idx_r;
    acc_we_s     = we_r;
    acc_sel_s    = sel_r;
    acc_wdata_s  = wdata_r;
    case (state_r)
      IDLE: begin
        accept_s     = mem_ce;
        enter_done_s = mem_ce & (WAIT_C == 4'd0);
        acc_idx_s    = addr[ADDR_WIDTH+1:2];
        acc_we_s     = mem_we;
        acc_sel_s    = memsel;
        acc_wdata_s  = wdata;
      end
      BUSY: begin
        enter_done_s = (count_r == 4'd1);
      end
      default: begin
        enter_done_s = 1'b0;
      end
    endcase
    wr_en_s = enter_done_s & acc_we_s & lane_ok(acc_sel_s);
  end

  // Handshake FSM with registered completion pulse, error flag and read word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      count_r   <= 4'd0;
      idx_r     <= '0;
      we_r      <= 1'b0;
      sel_r     <= 4'd0;
      wdata_r   <= 32'd0;
      rdata_r   <= 32'd0;
      data_ok_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      data_ok_r <= enter_done_s;
      err_r     <= enter_done_s & acc_we_s & ~lane_ok(acc_sel_s);
      if (enter_done_s && !acc_we_s) begin
        rdata_r <= mem_r[acc_idx_s];
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            idx_r   <= acc_idx_s;
            we_r    <= acc_we_s;
            sel_r   <= acc_sel_s;
            wdata_r <= acc_wdata_s;
            count_r <= WAIT_C;
            state_r <= (WAIT_C == 4'd0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          count_r <= count_r - 4'd1;
          if (count_r == 4'd1) begin
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && acc_sel_s[b]) begin
        mem_r[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
      end
    end
  end

  assign stall   = resetn & ((state_r == BUSY) | accept_s);
  assign rdata   = rdata_r;
  assign data_ok = data_ok_r;
  assign err     = err_r;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized and directed bench for data_sram_responder at WAIT_CYCLES 0, 1 and 3,
// checked every cycle against a cycle-count/array reference model.
module tb_data_sram_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ce      [NI];
  logic        we      [NI];
  logic [3:0]  sel     [NI];
  logic [31:0] addr    [NI];
  logic [31:0] wdata   [NI];
  logic [31:0] rdata   [NI];
  logic        stall   [NI];
  logic        data_ok [NI];
  logic        err     [NI];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] mem_m   [NI][1024];
  logic [31:0] exp_rd  [NI];
  bit          pend    [NI];
  int          done_at [NI];
  int          free_at [NI];
  bit          p_we    [NI];
  logic [3:0]  p_sel   [NI];
  logic [9:0]  p_idx   [NI];
  logic [31:0] p_wd    [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .resetn(resetn), .mem_ce(ce[0]), .mem_we(we[0]), .memsel(sel[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .stall(stall[0]),
    .data_ok(data_ok[0]), .err(err[0]));
  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .resetn(resetn), .mem_ce(ce[1]), .mem_we(we[1]), .memsel(sel[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .stall(stall[1]),
    .data_ok(data_ok[1]), .err(err[1]));
  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .resetn(resetn), .mem_ce(ce[2]), .mem_we(we[2]), .memsel(sel[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .stall(stall[2]),
    .data_ok(data_ok[2]), .err(err[2]));

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic bit legal(input logic [3:0] s);
    return s inside {4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
  endfunction

  function automatic logic [31:0] pool_addr(input int k);
    logic [31:0] a;
    int          word;
    word    = (k < 17) ? k : ((k == 17) ? 32 : 64);
    a       = $urandom;
    a[11:2] = 10'(word);
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle model: a request seen while free is accepted, completes WAIT+1 cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit e_stall, e_ok, e_err;
      e_stall = 1'b0; e_ok = 1'b0; e_err = 1'b0;
      if (!resetn) begin
        pend[i]    = 1'b0;
        free_at[i] = 0;
        exp_rd[i]  = 32'd0;
      end else begin
        if (!pend[i] && ce[i] && cyc >= free_at[i]) begin
          pend[i]    = 1'b1;
          done_at[i] = cyc + wc(i) + 1;
          free_at[i] = done_at[i] + 1;
          p_we[i]    = we[i];
          p_sel[i]   = sel[i];
          p_idx[i]   = addr[i][11:2];
          p_wd[i]    = wdata[i];
        end
        if (pend[i]) begin
          if (cyc < done_at[i]) begin
            e_stall = 1'b1;
          end else begin
            e_ok    = 1'b1;
            pend[i] = 1'b0;
            if (p_we[i]) begin
              if (legal(p_sel[i])) begin
                for (int b = 0; b < 4; b++)
                  if (p_sel[i][b]) mem_m[i][p_idx[i]][8*b +: 8] = p_wd[i][8*b +: 8];
              end else begin
                e_err = 1'b1;
              end
            end else begin
              exp_rd[i] = mem_m[i][p_idx[i]];
            end
          end
        end
      end
      check($sformatf("u%0d stall", i),   {31'd0, stall[i]},   {31'd0, e_stall});
      check($sformatf("u%0d data_ok", i), {31'd0, data_ok[i]}, {31'd0, e_ok});
      check($sformatf("u%0d err", i),     {31'd0, err[i]},     {31'd0, e_err});
      check($sformatf("u%0d rdata", i),   rdata[i],            exp_rd[i]);
    end
  end

  // Drive one request (caller is just past a rising edge) and wait for its data_ok.
  task automatic access(input int i, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat, output int tdone);
    int t0, n;
    ce[i] = 1'b1; we[i] = w; sel[i] = s; addr[i] = a; wdata[i] = d;
    t0 = cyc; n = 0;
    rd = 32'd0; e = 1'b0; lat = -1; tdone = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!data_ok[i] && n < 40);
    if (data_ok[i]) begin
      rd = rdata[i]; e = err[i]; lat = cyc - t0; tdone = cyc;
    end else begin
      check($sformatf("u%0d data_ok timeout", i), {31'd0, data_ok[i]}, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int i, input int n);
    ce[i] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat, td, prev;

    resetn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; sel[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    @(posedge clk); #1;
    check("reset rdata", rdata[1], 32'd0);
    check("reset data_ok", {31'd0, data_ok[1]}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // known contents for every word the rest of the run touches
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 19; k++) access(i, 1'b1, 4'hF, pool_addr(k), $urandom, r, e, lat, td);
      idle(i, 1);
    end

    // directed sequence at WAIT_CYCLES=1
    access(1, 1'b1, 4'hF, 32'h40, 32'h1234_5678, r, e, lat, td);
    check("w1 write latency", 32'(lat), 32'd2);
    check("w1 write err", {31'd0, e}, 32'd0);
    access(1, 1'b0, 4'hF, 32'h40, 32'd0, r, e, lat, td);
    check("w1 read 0x40", r, 32'h1234_5678);
    check("w1 read latency", 32'(lat), 32'd2);
    access(1, 1'b1, 4'hF, 32'h80, 32'hAABB_CCDD, r, e, lat, td);
    access(1, 1'b1, 4'b0100, 32'h80, 32'h1111_1111, r, e, lat, td);
    access(1, 1'b0, 4'hF, 32'h80, 32'd0, r, e, lat, td);
    check("lane 0100", r, 32'hAA11_CCDD);
    access(1, 1'b1, 4'b0011, 32'h80, 32'h2233_2233, r, e, lat, td);
    access(1, 1'b0, 4'hF, 32'h80, 32'd0, r, e, lat, td);
    check("lane 0011", r, 32'hAA11_2233);
    access(1, 1'b1, 4'b1010, 32'h80, 32'hDEAD_DEAD, r, e, lat, td);
    check("illegal lane err", {31'd0, e}, 32'd1);
    access(1, 1'b0, 4'b0000, 32'h80, 32'd0, r, e, lat, td);
    check("illegal lane no write", r, 32'hAA11_2233);
    check("read sel 0000 err", {31'd0, e}, 32'd0);
    access(1, 1'b1, 4'hF, 32'h0000_0004, 32'h5A5A_5A5A, r, e, lat, td);
    access(1, 1'b0, 4'hF, 32'h0000_1004, 32'd0, r, e, lat, td);
    check("alias 0x1004", r, 32'h5A5A_5A5A);
    idle(1, 1);

    // back-to-back reads with mem_ce held through DONE
    for (int i = 0; i < NI; i += 2) begin
      prev = -1;
      for (int k = 0; k < 5; k++) begin
        access(i, 1'b0, 4'hF, pool_addr(k), 32'd0, r, e, lat, td);
        check($sformatf("u%0d b2b latency", i), 32'(lat), 32'(wc(i) + 1));
        if (prev >= 0) check($sformatf("u%0d b2b spacing", i), 32'(td - prev), 32'(wc(i) + 2));
        prev = td;
      end
      idle(i, 1);
    end

    // reset in the middle of a WAIT_CYCLES=3 write
    access(2, 1'b1, 4'hF, 32'h100, 32'hCAFE_F00D, r, e, lat, td);
    ce[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 32'h100; wdata[2] = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("rst stall", {31'd0, stall[2]}, 32'd0);
    check("rst data_ok", {31'd0, data_ok[2]}, 32'd0);
    check("rst err", {31'd0, err[2]}, 32'd0);
    check("rst rdata", rdata[2], 32'd0);
    ce[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    access(2, 1'b0, 4'hF, 32'h100, 32'd0, r, e, lat, td);
    check("rst write dropped", r, 32'hCAFE_F00D);
    idle(2, 1);

    // randomized traffic, including illegal lane patterns and idle gaps
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 40; n++) begin
        access(i, 1'($urandom_range(0, 1)), 4'($urandom), pool_addr($urandom_range(0, 18)),
               $urandom, r, e, lat, td);
        if ($urandom_range(0, 3) == 0) idle(i, $urandom_range(1, 2));
      end
      idle(i, 2);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
